// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide RAM initiator and its RAM bench.
package mem_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Byte index within a 16-bit access (little-endian).
  localparam logic IdxLo = 1'b0;
  localparam logic IdxHi = 1'b1;

endpackage

// File: rtl/mem_master.sv
// Bus initiator: splits 8/16-bit load/store requests into single-byte RAM
// transactions with a ready handshake and a per-byte timeout.
module mem_master
  import mem_pkg::*;
#(
  parameter int unsigned size_addr = 8,
  parameter int unsigned timeout   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic                 wide,
  input  logic [size_addr-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [size_addr-1:0] mem_address,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ready_r,
  input  logic                 mem_ready_w
);

  localparam int unsigned TimerW = $clog2(timeout);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(timeout - 1);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic                   wide_q, wide_d;
  logic [size_addr-1:0]   addr_q, addr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic                   idx_q, idx_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  // Load bytes collected so far; published to rdata only on completion.
  logic [15:0]            rbuf_q, rbuf_d;
  logic [15:0]            rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [size_addr-1:0]   mem_address_q, mem_address_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;
  logic                   ready_match;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    wide_d        = wide_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    rbuf_d        = rbuf_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    ready_match   = we_q ? mem_ready_w : mem_ready_r;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d       = StIssue;
          we_d          = we;
          wide_d        = wide;
          addr_d        = addr;
          wdata_d       = wdata;
          idx_d         = IdxLo;
          err_d         = 1'b0;
          rbuf_d        = '0;
          mem_read_d    = !we;
          mem_write_d   = we;
          mem_address_d = addr;
          mem_wdata_d   = wdata[7:0];
        end
      end
      StIssue: begin
        state_d = StWait;
        timer_d = '0;
      end
      StWait: begin
        // A ready in the last timer cycle still wins over the timeout.
        if (ready_match) begin
          if (!we_q) begin
            if (idx_q == IdxHi) rbuf_d[15:8] = mem_rdata;
            else                rbuf_d[7:0]  = mem_rdata;
          end
          if (!wide_q || idx_q == IdxHi) begin
            state_d = StDone;
          end else begin
            state_d       = StIssue;
            idx_d         = IdxHi;
            mem_read_d    = !we_q;
            mem_write_d   = we_q;
            mem_address_d = addr_q + size_addr'(1);
            mem_wdata_d   = wdata_q[15:8];
          end
        end else if (timer_q == TimerLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Loads publish on completion; uncaptured bytes are already zero in rbuf.
    if (state_q == StWait && state_d == StDone && !we_q) rdata_d = rbuf_d;

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      wide_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      idx_q         <= IdxLo;
      timer_q       <= '0;
      rbuf_q        <= '0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      wide_q        <= wide_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      rbuf_q        <= rbuf_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator that drives the byte-wide RAM port on behalf of the CPU core. Accepts one 8- or 16-bit load/store request at a time and splits it into single-byte RAM transactions, little-endian. Tracks the RAM's ready_r/ready_w handshake and reports completion, or a timeout error. Sits between the core's load/store unit and the `ram` instance.

## Interface
- size_addr, 8, RAM address width.
- timeout, 8, cycles spent in WAIT without the matching ready before the access aborts with err (≥2).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  1  start request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- wide  in  1  1 = 16-bit access (two bytes), 0 = 8-bit.
- addr  in  size_addr  byte address of the low byte.
- wdata  in  16  store data; [7:0] goes to addr, [15:8] goes to addr+1.
- rdata  out  16  load result; holds until the next load completes.
- busy  out  1  high from the cycle after req is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = timeout abort.
- mem_read  out  1  to ram read.
- mem_write  out  1  to ram write.
- mem_address  out  size_addr  to ram address.
- mem_wdata  out  8  to ram data_in.
- mem_rdata  in  8  from ram data_out.
- mem_ready_r  in  1  from ram ready_r.
- mem_ready_w  in  1  from ram ready_w.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: busy=0. If req=1, latch we, wide, addr, wdata; set byte index idx=0 and err=0; go to ISSUE.
- ISSUE: drive mem_read=!we or mem_write=we for exactly this cycle. Drive mem_address = addr+idx, truncated to size_addr bits so it wraps. Drive mem_wdata = wdata byte idx. Clear the timer. Go to WAIT.
- WAIT: mem_read and mem_write are 0. The matching ready is mem_ready_r for loads and mem_ready_w for stores; the other ready is ignored.
  - On the matching ready during a load, capture mem_rdata into rdata byte idx.
  - If idx is the last byte, go to DONE. Otherwise set idx=1 and go to ISSUE.
  - If there is no ready, increment the timer. When timer = timeout-1, set err=1 and go to DONE. A timeout on byte 0 skips byte 1.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. req is ignored here.
- Byte load writes rdata[15:8]=0. A load that times out leaves already-captured bytes in rdata and zeroes the rest.
- Stores never modify rdata.
- Ready pulses seen in IDLE, ISSUE or DONE are ignored.
- Wrap case: a wide access at addr = all-ones touches all-ones, then 0.

## Timing
- Reset values:
  - state = IDLE.
  - busy, done, err, mem_read, mem_write = 0.
  - rdata, mem_address, mem_wdata = 0.
- All outputs are registered.
- Byte access: req sampled at edge E0; ISSUE in cycle E0–E1; ram ready in cycle E1–E2; done=1 in cycle E2–E3. Three cycles from req to done, one access per 4 cycles including IDLE.
- Wide access: done two cycles later than a byte access (5 cycles from req).
- The core must not change addr/wdata expectations mid-access. Inputs are latched, so changes after acceptance have no effect.
- A reset asserted in any state returns the block to IDLE at that edge. mem_read and mem_write are 0 from the next cycle. No done is produced.
- req held high continuously starts a new access in each IDLE cycle.

## Structure
- Shared package mem_pkg holds the state encodings (IDLE/ISSUE/WAIT/DONE, 2 bits) and the byte-index constants. The `ram` bench reuses it.
- Single module. The timeout counter is small enough to stay inline, so no sub-module.

## Test plan
- Byte store, then byte load, to real ram: store 8'h5A at 8'h10, then load 8'h10 → rdata=16'h005A, err=0, done exactly 3 cycles after each req.
- Wide store/load: store 16'hBEEF at 8'h20 → ram[8'h20]=8'hEF and ram[8'h21]=8'hBE; wide load returns 16'hBEEF with done 5 cycles after req.
- Wrap: wide store 16'h1234 at 8'hFF (size=256) → ram[8'hFF]=8'h34 and ram[8'h00]=8'h12.
- Timeout: stub RAM that never asserts ready, timeout=8, byte load → done with err=1 at cycle 1+1+8 after req; mem_read high for exactly one cycle.
- Wrong-ready filtering: during a load, pulse mem_ready_w only, then mem_ready_r two cycles later → done fires only after mem_ready_r and rdata captures that cycle's mem_rdata.
- Reset mid-WAIT of a wide load → no done, busy=0 and mem_read=0 the next cycle; a subsequent byte load completes normally.
